// File: rtl/key_debounce.sv
// key_debounce: conditions the active-low, bouncing user push-button into a
// debounced level plus single-cycle press / release / long-press events and an
// 8-bit wrapping press counter, all on the sys_clk domain.
//
// Optional feature (compile-time macro KEY_REPEAT_EN): while the key stays held
// after key_long, key_repeat pulses every REPEAT_CYCLES cycles. Without the
// macro key_repeat is tied low and no repeat counter exists.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 PRESS_WAIT, 2 HELD, 3 RELEASE_WAIT.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 24000000,
    parameter int REPEAT_CYCLES   = 6000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_n,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic       key_repeat,
    output logic [7:0] key_count,
    output logic [1:0] dbg_state
);

    // Counters only need to reach N-1, so $clog2(N) bits are enough.
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    logic              sync1_q, sync2_q;
    logic              key_sync;
    state_e            state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic [7:0]        count_q, count_d;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              repeat_q, repeat_d;
`endif

    // Two-flop synchroniser for the asynchronous pin; flops idle at 1 (released).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Active-high view of the synchronised pin; nothing else looks at key_n.
    assign key_sync = ~sync2_q;

    // Next-state and registered-output logic for the debounce FSM.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;
`ifdef KEY_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        repeat_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_sync) begin
                    state_d   = ST_PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_sync) begin
                    // Bounce: drop back silently.
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = ST_HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_HELD: begin
                // Hold time saturates so long-press fires once per press.
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if ((hold_cnt_q == HOLD_LAST) && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d   = '0;
                end else if (long_done_q) begin
                    if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
                if (!key_sync) begin
                    state_d   = ST_RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // Hold and repeat timers stay frozen here.
                if (key_sync) begin
                    state_d = ST_HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat counter and pulse register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign key_repeat = repeat_q;
`else
    assign key_repeat = 1'b0;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_count   = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random stimulus for key_debounce with a
// run-length reference model; build with or without +define+KEY_REPEAT_EN.
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic       key_level, key_press, key_release, key_long, key_repeat;
  logic [7:0] key_count;
  logic [1:0] dbg_state;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .key_n(key_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long),
    .key_repeat(key_repeat),
    .key_count(key_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The key is accepted once the synchronised level has differed from the
  // debounced level for D+1 consecutive samples. Held time counts only the
  // samples where the key is pressed and no release is pending.
  logic       m_s1, m_s2, m_ks, m_lvl, m_hold_edge;
  int         m_run, m_held;
  logic       m_press, m_release, m_long, m_repeat;
  logic [7:0] m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_held = 0;
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0; m_repeat = 1'b0;
      m_count = 8'd0;
    end else begin
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0; m_repeat = 1'b0;
      m_ks = ~m_s2;
      m_s2 = m_s1;
      m_s1 = key_n;
      m_hold_edge = m_lvl && (m_run == 0);
      if (m_ks != m_lvl) m_run++;
      else m_run = 0;
      if (m_hold_edge) begin
        m_held++;
        if (m_held == L) m_long = 1'b1;
`ifdef KEY_REPEAT_EN
        else if (m_held > L && ((m_held - L) % R) == 0) m_repeat = 1'b1;
`endif
      end
      if (m_run == D + 1) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        if (m_lvl) begin
          m_press = 1'b1;
          m_count = m_count + 8'd1;
          m_held = 0;
        end else begin
          m_release = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("level", key_level, m_lvl);
    check("press", key_press, m_press);
    check("release", key_release, m_release);
    check("long", key_long, m_long);
    check("repeat", key_repeat, m_repeat);
    check("count", key_count, m_count);
    check("state", dbg_state, {m_lvl, (m_run != 0)});
  end

  int cnt_press = 0, cnt_release = 0, cnt_long = 0, cnt_repeat = 0;
  always @(negedge clk) begin
    if (key_press) cnt_press++;
    if (key_release) cnt_release++;
    if (key_long) cnt_long++;
    if (key_repeat) cnt_repeat++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return key_press;
      1: return key_release;
      default: return key_long;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (sel(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_%0d: no pulse within %0d cycles, got none required one", which, maxc);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int e0, at, p, base_p, base_r, base_l, base_rep;
    key_n = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_level", key_level, 0);
    check("rst_count", key_count, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Bounce rejection: 3 low, 1 high, 3 low, then high.
    base_p = cnt_press;
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; tick();
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; repeat (15) tick();
    check("bounce_no_press", cnt_press - base_p, 0);
    check("bounce_level", key_level, 0);
    check("bounce_count", key_count, 0);

    // Clean press and release.
    key_n = 1'b0; e0 = cyc + 1;
    wait_sig(0, 20, at);
    check("press_latency", at - e0, D + 2);
    check("press_level", key_level, 1);
    check("press_count", key_count, 1);
    repeat (3) tick();
    key_n = 1'b1; e0 = cyc + 1;
    wait_sig(1, 20, at);
    check("release_latency", at - e0, D + 2);
    check("release_level", key_level, 0);
    repeat (10) tick();

    // Release-side glitch while held: no release, hold time frozen.
    base_r = cnt_release;
    key_n = 1'b0;
    wait_sig(0, 20, p);
    repeat (5) tick();
    key_n = 1'b1; repeat (2) tick();
    key_n = 1'b0;
    wait_sig(2, 60, at);
    check("glitch_no_release", cnt_release - base_r, 0);
    check("glitch_long_delay", at - p, L + 2);
    key_n = 1'b1;
    wait_sig(1, 20, at);
    repeat (10) tick();

    // Long press: hold 40 cycles.
    base_l = cnt_long; base_r = cnt_release; base_rep = cnt_repeat;
    key_n = 1'b0;
    wait_sig(0, 20, p);
    wait_sig(2, 40, at);
    check("long_after_press", at - p, L);
    repeat (13) tick();
    key_n = 1'b1;
    wait_sig(1, 30, at);
    repeat (5) tick();
    check("long_once", cnt_long - base_l, 1);
    check("long_release_once", cnt_release - base_r, 1);
`ifdef KEY_REPEAT_EN
    check("repeat_pulses", cnt_repeat - base_rep, 3);
`else
    check("repeat_pulses", cnt_repeat - base_rep, 0);
`endif
    repeat (5) tick();

    // Reset mid-press with the key held through reset.
    key_n = 1'b0;
    wait_sig(0, 20, p);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_level", key_level, 0);
    check("midrst_count", key_count, 0);
    check("midrst_press", key_press, 0);
    tick();
    rst = 1'b0; e0 = cyc + 1;
    wait_sig(0, 20, at);
    check("postrst_latency", at - e0, D + 2);
    check("postrst_count", key_count, 1);
    key_n = 1'b1;
    wait_sig(1, 20, at);
    repeat (5) tick();

    // Count wrap: 256 clean presses from zero.
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0; repeat (2) tick();
    for (int i = 0; i < 256; i++) begin
      key_n = 1'b0;
      wait_sig(0, 20, at);
      check("wrap_count", key_count, (i + 1) % 256);
      repeat (2) tick();
      key_n = 1'b1;
      wait_sig(1, 20, at);
      repeat (3) tick();
    end

    // Random segments checked only by the model.
    for (int s = 0; s < 200; s++) begin
      int len;
      key_n = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      repeat (len) tick();
    end
    key_n = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
